// File: rtl/bit_permute_pipe.sv
// bit_permute_pipe: one-stage pipelined bit permutation unit with a streaming handshake.
//
// Each output bit is picked from an input bit, forced to zero, or XORed with its own
// position. The choice depends on the per-beat mode and on a source table that can be
// reprogrammed at runtime.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o  input handshake; in_data_i and in_mode_i are sampled on accept
//   in_mode_i              0 pass, 1 reverse, 2 table, 3 table-xor
//   out_valid_o/out_ready_i output handshake; out_data_o is the registered permuted word
//   cfg_we_i               table write strobe: dst cfg_idx_i <- src cfg_src_i, zero cfg_zero_i
//   cfg_err_o              sticky flag, set by an out-of-range table write
//   perm_ok_o              table is a bijection with no zeroed entries (one cycle behind)
//   beat_cnt_o             wrapping count of output handshakes
module bit_permute_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [IDX_W-1:0] cfg_src_i,
  input  logic             cfg_zero_i,
  output logic             cfg_err_o,
  output logic             perm_ok_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  typedef enum logic [1:0] {
    ModePass     = 2'd0,
    ModeRev      = 2'd1,
    ModeTable    = 2'd2,
    ModeTableXor = 2'd3
  } mode_e;

  // Source table
  logic [IDX_W-1:0] src_q [WIDTH];
  logic [IDX_W-1:0] src_d [WIDTH];
  logic [WIDTH-1:0] zero_q, zero_d;

  // Output stage and status
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             cfg_err_q, cfg_err_d;
  logic             perm_ok_q, perm_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             out_fire;
  logic             cfg_in_range;
  logic [WIDTH-1:0] perm;
  logic [WIDTH-1:0] src_hit;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  // Only reachable as false when WIDTH is not a power of two.
  assign cfg_in_range = (32'(cfg_idx_i) < WIDTH) && (32'(cfg_src_i) < WIDTH);

  // Permutation uses the table as registered, so a write on the accept edge is not seen.
  always_comb begin
    perm = '0;
    unique case (mode_e'(in_mode_i))
      ModePass: perm = in_data_i;
      ModeRev: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          perm[i] = in_data_i[WIDTH-1-i];
        end
      end
      ModeTable: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          perm[i] = zero_q[i] ? 1'b0 : in_data_i[src_q[i]];
        end
      end
      ModeTableXor: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          perm[i] = zero_q[i] ? 1'b0 : (in_data_i[src_q[i]] ^ in_data_i[i]);
        end
      end
      default: perm = '0;
    endcase
  end

  // Table update and sticky error
  always_comb begin
    src_d     = src_q;
    zero_d    = zero_q;
    cfg_err_d = cfg_err_q;
    if (cfg_we_i) begin
      if (cfg_in_range) begin
        src_d[cfg_idx_i]  = cfg_src_i;
        zero_d[cfg_idx_i] = cfg_zero_i;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // With WIDTH entries, covering every source index is equivalent to a bijection.
  always_comb begin
    src_hit = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      for (int j = 0; j < int'(WIDTH); j++) begin
        if (src_q[i] == IDX_W'(j)) begin
          src_hit[j] = 1'b1;
        end
      end
    end
    perm_ok_d = (&src_hit) && !(|zero_q);
  end

  // Output register and beat counter
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = perm;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        src_q[i] <= IDX_W'(i);
      end
      zero_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      perm_ok_q   <= 1'b1;
      cnt_q       <= '0;
    end else begin
      src_q       <= src_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      perm_ok_q   <= perm_ok_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign cfg_err_o   = cfg_err_q;
  assign perm_ok_o   = perm_ok_q;
  assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Directed testbench for bit_permute_pipe: an 8-bit instance covers modes, table
// programming, perm_ok timing, backpressure and streaming. A 6-bit instance with a 3-bit
// counter covers out-of-range config writes and counter wrap. Both instances share one
// reset, which is also asserted mid-operation.
module tb_bit_permute_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] in_mode;
  logic       cfg_we, cfg_zero, cfg_err, perm_ok;
  logic [2:0] cfg_idx, cfg_src;
  logic [15:0] beat_cnt;

  // 6-bit instance
  logic       in_valid_6, in_ready_6, out_valid_6, out_ready_6;
  logic [5:0] in_data_6, out_data_6;
  logic [1:0] in_mode_6;
  logic       cfg_we_6, cfg_zero_6, cfg_err_6, perm_ok_6;
  logic [2:0] cfg_idx_6, cfg_src_6;
  logic [2:0] beat_cnt_6;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  bit_permute_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_mode_i(in_mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_src_i(cfg_src), .cfg_zero_i(cfg_zero),
    .cfg_err_o(cfg_err), .perm_ok_o(perm_ok), .beat_cnt_o(beat_cnt)
  );

  bit_permute_pipe #(.WIDTH(6), .CNT_W(3)) u_dut6 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid_6), .in_ready_o(in_ready_6), .in_data_i(in_data_6),
    .in_mode_i(in_mode_6),
    .out_valid_o(out_valid_6), .out_ready_i(out_ready_6), .out_data_o(out_data_6),
    .cfg_we_i(cfg_we_6), .cfg_idx_i(cfg_idx_6), .cfg_src_i(cfg_src_6), .cfg_zero_i(cfg_zero_6),
    .cfg_err_o(cfg_err_6), .perm_ok_o(perm_ok_6), .beat_cnt_o(beat_cnt_6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic cfg_wr(input logic [2:0] idx, input logic [2:0] src, input logic zero);
    cfg_we = 1'b1; cfg_idx = idx; cfg_src = src; cfg_zero = zero;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] m,
                      input logic [7:0] exp);
    in_valid = 1'b1; in_data = d; in_mode = m; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
    check({tag, "_cnt"}, 32'(beat_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [7:0] s [10];
    in_valid = 0; in_data = 0; in_mode = 0; out_ready = 0;
    cfg_we = 0; cfg_idx = 0; cfg_src = 0; cfg_zero = 0;
    in_valid_6 = 0; in_data_6 = 0; in_mode_6 = 0; out_ready_6 = 0;
    cfg_we_6 = 0; cfg_idx_6 = 0; cfg_src_6 = 0; cfg_zero_6 = 0;

    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_cnt", 32'(beat_cnt), 32'd0);
    check("rst_permok", 32'(perm_ok), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed modes
    beat("pass_a5", 8'hA5, 2'd0, 8'hA5);
    beat("rev_01", 8'h01, 2'd1, 8'h80);
    beat("rev_0e", 8'h0E, 2'd1, 8'h70);

    // Program a true permutation
    cfg_wr(3'd7, 3'd7, 1'b0); cfg_wr(3'd6, 3'd6, 1'b0);
    cfg_wr(3'd5, 3'd4, 1'b0); cfg_wr(3'd4, 3'd5, 1'b0);
    cfg_wr(3'd3, 3'd0, 1'b0); cfg_wr(3'd2, 3'd3, 1'b0);
    cfg_wr(3'd1, 3'd2, 1'b0); cfg_wr(3'd0, 3'd1, 1'b0);
    @(negedge clk);
    check("tbl_permok", 32'(perm_ok), 32'd1);
    beat("tbl_01", 8'h01, 2'd2, 8'h08);
    beat("tbl_10", 8'h10, 2'd2, 8'h20);

    // Duplicate source: perm_ok drops one cycle after the write edge
    cfg_wr(3'd1, 3'd0, 1'b0);
    check("dup_permok_lag", 32'(perm_ok), 32'd1);
    @(negedge clk);
    check("dup_permok", 32'(perm_ok), 32'd0);
    beat("dup_01", 8'h01, 2'd2, 8'h0A);

    // Write and accept on the same edge: beat still sees the old table
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_src = 3'd2; cfg_zero = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; in_mode = 2'd2; out_ready = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    check("same_edge_data", 32'(out_data), 32'h0A);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    beat("after_restore", 8'h01, 2'd2, 8'h08);

    // Zeroed entry and table-xor on a fresh identity table
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    cfg_wr(3'd0, 3'd0, 1'b1);
    cfg_wr(3'd1, 3'd0, 1'b0);
    @(negedge clk);
    check("zero_permok", 32'(perm_ok), 32'd0);
    beat("xor_03", 8'h03, 2'd3, 8'h00);
    beat("xor_01", 8'h01, 2'd3, 8'h02);
    beat("zero_ff", 8'hFF, 2'd2, 8'hFE);

    // Backpressure: hold for 3 cycles, then 10-beat stream
    in_valid = 1'b1; in_data = 8'h3C; in_mode = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    in_data = 8'h00;
    repeat (3) begin
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'h3C);
      check("hold_cnt", 32'(beat_cnt), 32'(exp_cnt));
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) s[k] = 8'h10 + 8'(k * 7);
    out_ready = 1'b1; in_data = s[0];
    #1 check("stream_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(s[k]));
      if (k < 9) in_data = s[k+1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt += 11;
    check("stream_drain", 32'(out_valid), 32'd0);
    check("stream_cnt", 32'(beat_cnt), 32'(exp_cnt));

    // 6-bit instance: counter wraps at 8
    in_valid_6 = 1'b1; in_mode_6 = 2'd0; out_ready_6 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_data_6 = 6'(k + 1);
      @(negedge clk);
      check("w6_ready", 32'(in_ready_6), 32'd1);
    end
    in_valid_6 = 1'b0;
    @(negedge clk);
    check("w6_drain", 32'(out_valid_6), 32'd0);
    check("w6_wrap", 32'(beat_cnt_6), 32'd1);

    // Out-of-range writes are dropped and flagged
    cfg_we_6 = 1'b1; cfg_idx_6 = 3'd7; cfg_src_6 = 3'd0; cfg_zero_6 = 1'b1;
    @(negedge clk);
    cfg_we_6 = 1'b0;
    check("w6_err_idx", 32'(cfg_err_6), 32'd1);
    cfg_we_6 = 1'b1; cfg_idx_6 = 3'd2; cfg_src_6 = 3'd6; cfg_zero_6 = 1'b0;
    @(negedge clk);
    cfg_we_6 = 1'b0;
    @(negedge clk);
    check("w6_permok_kept", 32'(perm_ok_6), 32'd1);
    in_valid_6 = 1'b1; in_data_6 = 6'b101101; in_mode_6 = 2'd2;
    @(negedge clk);
    in_valid_6 = 1'b0;
    check("w6_tbl_ident", 32'(out_data_6), 32'h2D);
    // Legal write after an error: applied, flag stays set
    cfg_we_6 = 1'b1; cfg_idx_6 = 3'd0; cfg_src_6 = 3'd5; cfg_zero_6 = 1'b0;
    @(negedge clk);
    cfg_we_6 = 1'b0;
    @(negedge clk);
    check("w6_err_sticky", 32'(cfg_err_6), 32'd1);
    check("w6_permok_dup", 32'(perm_ok_6), 32'd0);
    in_valid_6 = 1'b1; in_data_6 = 6'b100000; in_mode_6 = 2'd2;
    @(negedge clk);
    in_valid_6 = 1'b0; out_ready_6 = 1'b0;
    check("w6_tbl_dup", 32'(out_data_6), 32'h21);

    // Asynchronous reset while a beat is held
    in_valid = 1'b1; in_data = 8'h5A; in_mode = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_valid_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_data", 32'(out_data), 32'd0);
    check("mid_cnt", 32'(beat_cnt), 32'd0);
    check("mid_permok", 32'(perm_ok), 32'd1);
    check("mid_err6", 32'(cfg_err_6), 32'd0);
    check("mid_permok6", 32'(perm_ok_6), 32'd1);
    check("mid_valid6", 32'(out_valid_6), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    beat("post_ff", 8'hFF, 2'd2, 8'hFF);
    beat("post_01", 8'h01, 2'd2, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_permute_pipe.md
Name: bit_permute_pipe

Overview:
- Parametrised, pipelined bit-permutation unit: each output bit `out_data[i]` is selected from an input bit, forced to zero, or XORed, according to a per-beat mode and a runtime-programmable source table.
- Generalises fixed-wiring permute blocks (identity, reverse, arbitrary mix, dropped bits, duplicated bits) to any width.
- Adds valid/ready streaming, a configuration port, and a bijection checker (`perm_ok`). The vectorization flow uses `perm_ok` to tell a true permutation apart from a lossy map.

Parameters:
- WIDTH, 8, data width in bits; must be at least 2.
- IDX_W, $clog2(WIDTH), width of bit-index fields; derived, not overridden.
- CNT_W, 16, width of the output beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WIDTH  input word.
- in_mode  input  2  per-beat mode, sampled with in_data: 0 pass, 1 reverse, 2 table, 3 table-xor.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  permuted word.
- cfg_we  input  1  table write strobe.
- cfg_idx  input  IDX_W  destination bit index being programmed.
- cfg_src  input  IDX_W  source bit index for that destination.
- cfg_zero  input  1  when 1, destination bit is forced to 0 in modes 2/3.
- cfg_err  output  1  sticky flag: out-of-range config write seen.
- perm_ok  output  1  table is a bijection with no zeroed entries.
- beat_cnt  output  CNT_W  count of output handshakes.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, cfg_err=0, beat_cnt=0, perm_ok=1.
  - Table is identity: src[i]=i, zero[i]=0.
- Datapath, one register stage, latency 1:
  - `in_ready = !out_valid || out_ready`, combinational; no combinational path from in_valid to out_valid.
  - On input accept, out_data is loaded next edge and out_valid=1.
  - out_valid stays 1 and out_data is held stable while out_valid && !out_ready.
  - On output handshake with no new accept, out_valid returns to 0 and out_data holds its last value.
  - Simultaneous output handshake and input accept is full throughput: one beat per cycle.
- Mode function, per bit i, computed on the accepted beat:
  - mode 0: out[i] = in[i].
  - mode 1: out[i] = in[WIDTH-1-i].
  - mode 2: out[i] = zero[i] ? 0 : in[src[i]].
  - mode 3: out[i] = zero[i] ? 0 : in[src[i]] ^ in[i].
- Config writes:
  - When cfg_we=1 and both cfg_idx < WIDTH and cfg_src < WIDTH: src[cfg_idx] <= cfg_src and zero[cfg_idx] <= cfg_zero at that edge.
  - The new entry applies to beats accepted on later edges, never to a beat accepted on the same edge.
  - A beat already in the output register is not altered.
  - When cfg_idx >= WIDTH or cfg_src >= WIDTH (only possible when WIDTH is not a power of 2): the write is dropped and cfg_err is set. cfg_err is cleared only by reset.
  - Config writes are legal at any time, independent of the handshake.
- perm_ok:
  - Registered; it reflects the table as of the previous edge, i.e. it updates 1 cycle after a write.
  - It is 1 iff no zero[i] is set and every source index 0..WIDTH-1 appears exactly once in src[].
  - Duplicated or dropped sources give 0.
- beat_cnt: increments on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: any held beat is discarded (out_valid=0) and the table returns to identity immediately.

Test Plan:
- After reset, send in_data=8'hA5 in mode 0 -> out_data=8'hA5 one cycle later; perm_ok=1; beat_cnt becomes 1 after the handshake.
- Mode 1, in_data=8'h01 -> out_data=8'h80; mode 1, in_data=8'h0E -> 8'h70.
- Program the table with dst:src pairs 7:7, 6:6, 5:4, 4:5, 3:0, 2:3, 1:2, 0:1, then mode 2 -> in 8'h01 gives 8'h08, in 8'h10 gives 8'h20, perm_ok=1. Then write 1:0 (duplicate) -> perm_ok=0 next cycle; in 8'h01 gives 8'h0A.
- Write 0 with cfg_zero=1 under the identity table, mode 3 with src[1]=0, in 8'h03 -> bit0=0, bit1=in0^in1=0; out 8'h00; perm_ok=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, beat_cnt unchanged. Then a streaming burst of 10 beats with out_ready=1 -> 10 outputs in 10 consecutive cycles, order preserved.
- WIDTH=6: write cfg_idx=7 -> table unchanged, cfg_err=1. Assert rst_n low while out_valid=1 -> out_valid=0 immediately, table back to identity, cfg_err=0.
